// File: rtl/traffic_light_ctrl_pkg.sv
// Shared phase codes, lamp encodings and the phase-to-lamp decode for the
// two-way intersection sequencer.
package traffic_light_ctrl_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LAMP_W  = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_NS_G = 3'd0,
    PH_NS_Y = 3'd1,
    PH_AR1  = 3'd2,
    PH_EW_G = 3'd3,
    PH_EW_Y = 3'd4,
    PH_AR2  = 3'd5,
    PH_WALK = 3'd6
  } phase_t;

  localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

  typedef struct packed {
    logic [LAMP_W-1:0] ns;
    logic [LAMP_W-1:0] ew;
    logic              walk;
  } lamps_t;

  // Moore decode; anything not a green/yellow phase (including code 7) is all-red.
  function automatic lamps_t decode_lamps(input phase_t ph);
    lamps_t l;
    l.ns   = LAMP_R;
    l.ew   = LAMP_R;
    l.walk = 1'b0;
    case (ph)
      PH_NS_G: l.ns   = LAMP_G;
      PH_NS_Y: l.ns   = LAMP_Y;
      PH_EW_G: l.ew   = LAMP_G;
      PH_EW_Y: l.ew   = LAMP_Y;
      PH_WALK: l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Loadable down-counter that times each light phase; load wins over counting
// and is not gated by en so the controller can force a reload.
module phase_timer #(
  parameter int unsigned CW      = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count <= CW'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Intersection sequencer: phase FSM driving the phase timer, pedestrian request
// latch and registered lamp decode.
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int unsigned G_TIME = 6,
  parameter int unsigned Y_TIME = 2,
  parameter int unsigned R_TIME = 1,
  parameter int unsigned W_TIME = 3,
  parameter int unsigned CW     = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic              ped_req,
  output logic [LAMP_W-1:0] ns_light,
  output logic [LAMP_W-1:0] ew_light,
  output logic              walk,
  output logic [PHASE_W-1:0] phase,
  output logic              tc
);

  phase_t        phase_q, phase_nxt;
  logic          ped_q, ped_nxt;
  logic          adv;
  logic          load;
  logic [CW-1:0] load_val;
  logic [CW-1:0] timer;
  logic          timer_zero;
  lamps_t        lamps_nxt;

  // Timer reload value for the first cycle of a phase.
  function automatic logic [CW-1:0] dwell(input phase_t ph);
    logic [CW-1:0] d;
    case (ph)
      PH_NS_Y, PH_EW_Y: d = CW'(Y_TIME - 1);
      PH_AR1, PH_AR2:   d = CW'(R_TIME - 1);
      PH_WALK:          d = CW'(W_TIME - 1);
      default:          d = CW'(G_TIME - 1);
    endcase
    return d;
  endfunction

  phase_timer #(
    .CW      (CW),
    .RST_VAL (G_TIME - 1)
  ) u_timer (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (timer),
    .zero     (timer_zero)
  );

  assign adv   = en & timer_zero;
  assign tc    = timer_zero & en;
  assign phase = PHASE_W'(phase_q);

  // Next phase, timer load and pedestrian latch; a new request beats the WALK clear.
  always_comb begin
    phase_nxt = phase_q;
    ped_nxt   = ped_q | ped_req;
    load      = adv;
    case (phase_q)
      PH_NS_G: if (adv) phase_nxt = PH_NS_Y;
      PH_NS_Y: if (adv) phase_nxt = PH_AR1;
      PH_AR1:  if (adv) phase_nxt = PH_EW_G;
      PH_EW_G: if (adv) phase_nxt = PH_EW_Y;
      PH_EW_Y: if (adv) phase_nxt = PH_AR2;
      PH_AR2: begin
        if (adv) begin
          if (ped_q) begin
            phase_nxt = PH_WALK;
            ped_nxt   = ped_req;
          end else begin
            phase_nxt = PH_NS_G;
          end
        end
      end
      PH_WALK: if (adv) phase_nxt = PH_NS_G;
      default: begin
        phase_nxt = PH_NS_G;
        load      = 1'b1;
      end
    endcase
    load_val  = dwell(phase_nxt);
    lamps_nxt = decode_lamps(phase_nxt);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      phase_q  <= PH_NS_G;
      ped_q    <= 1'b0;
      ns_light <= LAMP_G;
      ew_light <= LAMP_R;
      walk     <= 1'b0;
    end else begin
      phase_q  <= phase_nxt;
      ped_q    <= ped_nxt;
      ns_light <= lamps_nxt.ns;
      ew_light <= lamps_nxt.ew;
      walk     <= lamps_nxt.walk;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: the driver queues the expected per-cycle outputs, a negedge
// monitor pops and compares them and checks the lamp invariants every cycle.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, tc;

  traffic_light_ctrl dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .phase    (phase),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       tc;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_v;
  exp_t got_v;
  int   n_vec = 0;
  int   n_err = 0;

  // Expected lamps written straight from the phase table.
  function automatic exp_t mk(input logic [2:0] ph, input logic t);
    exp_t e;
    e.ph   = ph;
    e.tc   = t;
    e.walk = (ph == 3'd6);
    case (ph)
      3'd0:    begin e.ns = 3'b001; e.ew = 3'b100; end
      3'd1:    begin e.ns = 3'b010; e.ew = 3'b100; end
      3'd3:    begin e.ns = 3'b100; e.ew = 3'b001; end
      3'd4:    begin e.ns = 3'b100; e.ew = 3'b010; end
      default: begin e.ns = 3'b100; e.ew = 3'b100; end
    endcase
    return e;
  endfunction

  function automatic int dw(input int p);
    case (p)
      0, 3:    return 6;
      1, 4:    return 2;
      6:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic cyc(input logic c, input logic e, input logic p,
                     input logic [2:0] ph, input logic t);
    @(posedge clk);
    #1;
    clear   = c;
    en      = e;
    ped_req = p;
    sb_q.push_back(mk(ph, t));
  endtask

  task automatic run_ph(input int ph, input int ped_k);
    for (int k = 0; k < dw(ph); k++)
      cyc(1'b1, 1'b1, (k == ped_k), 3'(ph), (k == dw(ph) - 1));
  endtask

  task automatic period(input int ped_ph, input int ped_k, input bit with_walk);
    for (int p = 0; p < 6; p++) run_ph(p, (p == ped_ph) ? ped_k : -1);
    if (with_walk) run_ph(6, -1);
  endtask

  // Monitor: invariants every cycle, scoreboard compare whenever a vector is queued.
  always @(negedge clk) begin
    n_vec++;
    if ((ns_light != 3'b100 && ew_light != 3'b100) || !$onehot(ns_light) ||
        !$onehot(ew_light) || (walk != (phase == 3'd6))) begin
      n_err++;
      $display("FAIL invariant t=%0t: ns=%b ew=%b walk=%b phase=%0d (required one-hot, one side red, walk iff phase 6)",
               $time, ns_light, ew_light, walk, phase);
    end
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      got_v = '{ph: phase, ns: ns_light, ew: ew_light, walk: walk, tc: tc};
      n_vec++;
      if (got_v != exp_v) begin
        n_err++;
        $display("FAIL vector t=%0t: got ph=%0d ns=%b ew=%b walk=%b tc=%b, want ph=%0d ns=%b ew=%b walk=%b tc=%b",
                 $time, got_v.ph, got_v.ns, got_v.ew, got_v.walk, got_v.tc,
                 exp_v.ph, exp_v.ns, exp_v.ew, exp_v.walk, exp_v.tc);
      end
    end
  end

  initial begin
    // Power-on reset held across an edge with en=1.
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

    // Free run, two 18-cycle periods.
    period(-1, -1, 1'b0);
    period(-1, -1, 1'b0);

    // One-cycle request in EW_G gives a 21-cycle period with WALK.
    period(3, 2, 1'b1);
    period(-1, -1, 1'b0);

    // Freeze NS_G at timer=3 for 5 cycles, request during the freeze.
    run_ph(0, -1);
    run_ph(1, -1); run_ph(2, -1); run_ph(3, -1); run_ph(4, -1); run_ph(5, -1);
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int f = 0; f < 5; f++) cyc(1'b1, 1'b0, (f == 2), 3'd0, 1'b0);
    for (int k = 2; k < 6; k++) cyc(1'b1, 1'b1, 1'b0, 3'd0, (k == 5));
    for (int p = 1; p < 7; p++) run_ph(p, -1);

    // Request on the edge entering WALK earns a second WALK.
    run_ph(0, -1); run_ph(1, -1); run_ph(2, -1);
    run_ph(3, 0); run_ph(4, -1); run_ph(5, 0); run_ph(6, -1);
    period(-1, -1, 1'b1);
    period(-1, -1, 1'b0);

    // Mid-run clear with a pending request: full restart, request dropped.
    run_ph(0, -1); run_ph(1, -1); run_ph(2, -1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, (k == 1), 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    period(-1, -1, 1'b0);
    run_ph(0, -1);

    // Random en/ped_req soak; the monitor checks the invariants.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      clear   = 1'b1;
      en      = ($urandom_range(0, 3) != 0);
      ped_req = ($urandom_range(0, 15) == 0);
    end

    repeat (3) @(posedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
